// File: rtl/demux_collector.sv
// Serial-to-parallel collector: reassembles an N-bit word sent LSB first,
// one bit per valid cycle, and presents it with a one-cycle Done strobe.
module demux_collector #(
    parameter int unsigned N  = 7,
    parameter int unsigned IW = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          BitIn,
    input  logic          BitValid,
    output logic [N-1:0]  DataOut,
    output logic          Done,
    output logic          Busy,
    output logic [IW-1:0] Index
);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_t;

    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    // Top bit of the word is never buffered; it goes straight into DataOut.
    logic [N-2:0]  buffer_q, buffer_d;
    logic [N-1:0]  data_q, data_d;

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            index_q  <= '0;
            buffer_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            buffer_q <= buffer_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic; Start always wins over a same-cycle valid bit.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        buffer_d = buffer_q;
        data_d   = data_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d  = StCollect;
                    index_d  = '0;
                    buffer_d = '0;
                end
            end
            StCollect: begin
                if (Start) begin
                    index_d  = '0;
                    buffer_d = '0;
                end else if (index_q > LastIdx) begin
                    // Unreachable index: fall back to idle rather than wrap.
                    state_d = StIdle;
                    index_d = '0;
                end else if (BitValid) begin
                    if (index_q == LastIdx) begin
                        data_d  = {BitIn, buffer_q};
                        state_d = StDone;
                        index_d = '0;
                    end else begin
                        for (int unsigned i = 0; i < N - 1; i++) begin
                            if (index_q == IW'(i)) begin
                                buffer_d[i] = BitIn;
                            end
                        end
                        index_d = index_q + 1'b1;
                    end
                end
            end
            StDone: begin
                index_d = '0;
                if (Start) begin
                    state_d  = StCollect;
                    buffer_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                index_d = '0;
            end
        endcase
    end

    // Outputs come only from registers or decoded state.
    always_comb begin
        DataOut = data_q;
        Done    = (state_q == StDone);
        Busy    = (state_q == StCollect);
        Index   = index_q;
    end

endmodule

// File: tb/tb_demux_collector.sv
// Self-checking bench for demux_collector: table-driven basic word, hand-written
// multi-cycle sequences, and a Done/DataOut scoreboard.
module tb_demux_collector;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       BitIn = 1'b0;
    logic       BitValid = 1'b0;
    logic [6:0] DataOut;
    logic       Done;
    logic       Busy;
    logic [2:0] Index;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] sb_q[$];

    typedef struct {
        logic       s;
        logic       v;
        logic       b;
        logic       busy;
        logic [2:0] idx;
        logic       done;
        logic [6:0] data;
    } vec_t;

    demux_collector #(.N(7), .IW(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .BitIn    (BitIn),
        .BitValid (BitValid),
        .DataOut  (DataOut),
        .Done     (Done),
        .Busy     (Busy),
        .Index    (Index)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs, then check all outputs just after the edge.
    task automatic step(input logic s, input logic v, input logic b, input logic eb,
                        input logic [2:0] ei, input logic ed, input logic [6:0] edat,
                        input string tag);
        Start = s;
        BitValid = v;
        BitIn = b;
        @(posedge Clock);
        #1;
        chk({tag, "_busy"}, 32'(Busy), 32'(eb));
        chk({tag, "_index"}, 32'(Index), 32'(ei));
        chk({tag, "_done"}, 32'(Done), 32'(ed));
        chk({tag, "_data"}, 32'(DataOut), 32'(edat));
    endtask

    // Seven consecutive valid bits, LSB first; prev is the DataOut held meanwhile.
    task automatic word_bits(input logic [6:0] w, input logic [6:0] prev, input string tag);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, w[i], 1'b1, 3'(i + 1), 1'b0, prev, tag);
        end
        sb_q.push_back(w);
        step(1'b0, 1'b1, w[6], 1'b0, 3'd0, 1'b1, w, {tag, "_last"});
    endtask

    // Scoreboard: every Done must match the next queued word.
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge Clock);
            #2;
            if (Done) begin
                if (sb_q.size() == 0) begin
                    chk("sb_spurious_done", 32'(Done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_done_data", 32'(DataOut), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        logic [6:0] h;
        logic [6:0] w1;
        h = 7'b1001101;
        w1 = 7'b0101010;
        // Basic word: Start then bits 1,0,1,1,0,0,1 LSB first.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 7'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 7'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 7'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 7'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 7'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 7'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 7'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 7'b1001101};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'b1001101};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'b1001101};

        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_index", 32'(Index), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_data", 32'(DataOut), 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].done) sb_q.push_back(tbl[i].data);
            step(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].busy, tbl[i].idx, tbl[i].done,
                 tbl[i].data, $sformatf("basic%0d", i));
        end

        // Gapped valid: three idle cycles after bit 2, index holds at 3.
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, h, "gap_start");
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, h, "gap_b0");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, h, "gap_b1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, h, "gap_b2");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], 1'b1, 3'd3, 1'b0, h, "gap_hold");
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, h, "gap_b3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, h, "gap_b4");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, h, "gap_b5");
        sb_q.push_back(h);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, h, "gap_last");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, h, "gap_idle");

        // Restart mid-word: the bit on the restart cycle must not be captured.
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, h, "rs_start");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 3'(i + 1), 1'b0, h, "rs_part");
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, h, "rs_restart");
        word_bits(7'd0, h, "rs_word");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'd0, "rs_idle");

        // Back-to-back: Start during the DONE cycle.
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 7'd0, "b2b_start");
        word_bits(w1, 7'd0, "b2b_w1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, w1, "b2b_restart");
        word_bits(7'h7F, w1, "b2b_w2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'h7F, "b2b_idle");

        // Idle noise: no Start, nothing changes.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 3'd0, 1'b0,
                 7'h7F, "noise");
        end

        // Reset on the last-bit cycle: no delivery, no Done.
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 7'h7F, "rl_start");
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 3'(i + 1), 1'b0, 7'h7F, "rl_bits");
        end
        Reset = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'd0, "rl_reset");
        Reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 7'd0, "rl_post");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 7'd0, "rl_idle");

        #5;
        chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_collector.md
# demux_collector

Serial-to-parallel collector that reassembles a word sent one bit per valid cycle, LSB first. The upstream 7:1 bit selector emits the bits by stepping its 3-bit select 0,1,…,6. This block walks a matching write index and steers each incoming bit into the same position, so bit *i* of the collected word is the bit sent while the sender's select equalled *i*. It sits on the receive side of that link and hands a completed 7-bit word, with a one-cycle `Done` strobe, to downstream logic such as HEX/LEDR display or a register file.

## Interface
- `N`, default 7: bits per word; legal range 2–8.
- `IW`, default 3: index width; must satisfy 2^IW ≥ N.
- `Clock` input 1: rising-edge clock; the only clock.
- `Reset` input 1: synchronous, active-high reset.
- `Start` input 1: begin a new word; sampled every cycle.
- `BitIn` input 1: serial data bit.
- `BitValid` input 1: `BitIn` is meaningful this cycle.
- `DataOut` output N: last completed word; held between completions.
- `Done` output 1: one-cycle strobe; `DataOut` is new this cycle.
- `Busy` output 1: high while in COLLECT.
- `Index` output IW: position the next valid bit will be written to.

## Operation
- **States:**
  - IDLE (reset state).
  - COLLECT.
  - DONE: one-cycle state.
- **IDLE:**
  - `BitValid` is ignored.
  - `Start`=1 → COLLECT. `Index` is set to 0 and the internal buffer is cleared to 0.
  - `BitIn` on the Start cycle is discarded.
- **COLLECT:**
  - On each cycle with `BitValid`=1, `buffer[Index] <= BitIn` and `Index <= Index+1`.
  - Cycles with `BitValid`=0 change nothing. Gaps of any length are legal.
- **Last bit:** `BitValid`=1 while `Index`==N−1.
  - Writes the last bit.
  - `DataOut <= {BitIn, buffer[N-2:0]}`.
  - Next state is DONE.
- **DONE:**
  - `Done`=1 for exactly this cycle.
  - `Index` reads 0 and `Busy`=0.
  - Next state is IDLE, unless `Start`=1, which goes directly to COLLECT; a new word may start here.
- **Start while in COLLECT:**
  - Restarts collection: `Index` goes to 0, the buffer is cleared, and the partial word is discarded.
  - `DataOut` is unchanged. `Done` is not asserted.
  - A `BitValid` in that same cycle is discarded; Start has priority, including on the last-bit cycle.
- **Index range:** never exceeds N−1 and never wraps silently. Values ≥ N are unreachable; if decoded, treat them as IDLE.
- **`DataOut` stability:** changes only on the last-bit edge or on reset. It never exposes a partial word.

## Timing
- **Reset:** with `Reset`=1 at a rising edge, the state goes to IDLE, `Index` to 0, the buffer to 0, `DataOut` to 0, and `Done`/`Busy` to 0.
  - Reset overrides every other input, including a mid-word or last-bit cycle.
  - No word is delivered and `Done` does not pulse.
- **Output type:** all outputs are registered or decoded from state only. No combinational path exists from any input to any output.
- **Latency:** Start in cycle 0, then valid bits in consecutive cycles 1..N.
  - `DataOut` is updated and `Done`=1 in cycle N+1.
  - Minimum word period is N+1 cycles when Start is asserted in the DONE cycle.
- **`Busy`:** rises in the cycle after Start is sampled. It falls in the cycle `Done` is high.
- **`Index`:** increments on the edge that samples a valid bit, so it equals the count of bits accepted in the current word.

## Test plan
- **Basic word, LSB first:** Start, then bits 1,0,1,1,0,0,1 on consecutive cycles → `DataOut`=7'b1001101 and a single `Done` pulse 8 cycles after Start; `Busy` is high for 7 cycles.
- **Gapped valid:** same bits with `BitValid` low for 3 cycles between bit 2 and bit 3 → same `DataOut`; `Done` arrives 3 cycles later; `Index` holds at 3 during the gap.
- **Restart mid-word:** send 4 bits, then Start with `BitValid`=1 and `BitIn`=1 in the same cycle, then 7 zeros → the previous `DataOut` is held throughout, then `DataOut`=0; the bit on the Start cycle is not captured.
- **Back-to-back words:** Start in the DONE cycle, then 7'b1111111 → second `Done` exactly 8 cycles after the first; `DataOut` goes from the first word to 7'h7F.
- **Reset on last bit:** assert `Reset` on the cycle of bit 6 → `DataOut`=0, `Done` never pulses, state IDLE, `Index`=0; a following `BitValid` with no Start is ignored.
- **Idle noise:** toggle `BitIn`/`BitValid` for 20 cycles with `Start`=0 → `DataOut`, `Index`, `Busy` and `Done` are all unchanged.
